// File: rtl/denoise_pkg.sv
// rtl/denoise_pkg.sv - shared types and sizing helpers for the streaming colour-mask denoiser
package denoise_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fsm_state_t;

  // Default colour count; pixel word is COLORS+1 bits with the valid flag on top.
  localparam int DEFAULT_COLORS = 2;
  typedef logic [DEFAULT_COLORS:0] pixel_t;

  // Width needed to count every cell of an n_size x n_size window.
  function automatic int count_width(input int n_size);
    return $clog2(n_size * n_size + 1);
  endfunction

  // Steps between the newest pixel and the window centre (R lines plus R pixels).
  function automatic int flush_len(input int n_size, input int img_w);
    return (n_size / 2) * img_w + (n_size / 2);
  endfunction

endpackage

// File: rtl/denoise_color_mask_stream_line_buffer.sv
// rtl/denoise_color_mask_stream_line_buffer.sv - one-line pixel delay line (mask_line_buffer) advanced by step
module mask_line_buffer
  import denoise_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr_q;

  // The slot about to be overwritten holds the pixel written DEPTH steps ago.
  assign dout = mem[ptr_q];

  // Write the incoming pixel into the slot just read out.
  always_ff @(posedge clk) begin
    if (step) begin
      mem[ptr_q] <= din;
    end
  end

  // Circular pointer; contents are never cleared, only the pointer is.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (step) begin
      ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/denoise_color_mask_stream.sv
// rtl/denoise_color_mask_stream.sv - raster-stream colour-mask denoiser top; optional DENOISE_STATS_EN removal statistics
module denoise_color_mask_stream
  import denoise_pkg::*;
#(
  parameter int N_SIZE      = 5,
  parameter int COLORS      = 2,
  parameter int N_THRESHOLD = 5,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [COLORS:0]   in_pixel,
  output logic              out_valid,
  output logic              out_sof,
  output logic [COLORS:0]   out_pixel
`ifdef DENOISE_STATS_EN
  ,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] stat_removed,
  output logic                             stat_valid
`endif
);

  localparam int R   = N_SIZE / 2;
  localparam int LAG = flush_len(N_SIZE, IMG_W);
  localparam int CW  = count_width(N_SIZE);
  localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW  = $clog2(LAG + 1);

  localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(LAG);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(LAG - 1);
  localparam logic [CW-1:0] TH_C       = CW'(N_THRESHOLD);

  fsm_state_t state_q, state_d;

  logic            accept, sof_step, abort, step, emit, last_in, flush_done;
  logic [XW-1:0]   x_q, cx_q, c1x_q;
  logic [YW-1:0]   y_q, cy_q, c1y_q;
  logic [FW-1:0]   fill_q, flush_q;
  logic            v1_q;

  logic [COLORS:0] step_pixel;
  logic [COLORS:0] tap [N_SIZE];
  logic [COLORS:0] win [N_SIZE][N_SIZE];
  logic [CW-1:0]   cnt [COLORS];
  logic [COLORS:0] centre, result;

  // Next-state decode; also classifies each cycle as a step, frame start or abort.
  always_comb begin
    state_d    = state_q;
    accept     = in_valid & in_ready;
    sof_step   = 1'b0;
    abort      = 1'b0;
    step       = 1'b0;
    last_in    = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && in_sof) begin
          sof_step = 1'b1;
          step     = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          step = 1'b1;
          if (in_sof) begin
            sof_step = 1'b1;
            abort    = 1'b1;
          end else if (x_q == X_LAST && y_q == Y_LAST) begin
            last_in = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        step = 1'b1;
        if (flush_q == FLUSH_LAST) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    emit = step && !sof_step && (fill_q == FILL_FULL);
  end

  // State, in_ready, input position, fill/flush counters and centre coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      in_ready <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      fill_q   <= '0;
      flush_q  <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      c1x_q    <= '0;
      c1y_q    <= '0;
      v1_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != FLUSH);
      if (sof_step) begin
        x_q     <= XW'(1);
        y_q     <= '0;
        fill_q  <= FW'(1);
        flush_q <= '0;
        cx_q    <= '0;
        cy_q    <= '0;
      end else begin
        if (step && state_q == RUN) begin
          if (last_in) begin
            x_q <= '0;
            y_q <= '0;
          end else if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        if (step && state_q == FLUSH) begin
          flush_q <= flush_done ? '0 : flush_q + FW'(1);
        end
        if (step && fill_q != FILL_FULL) begin
          fill_q <= fill_q + FW'(1);
        end
        if (emit) begin
          if (cx_q == X_LAST) begin
            cx_q <= '0;
            cy_q <= (cy_q == Y_LAST) ? '0 : cy_q + YW'(1);
          end else begin
            cx_q <= cx_q + XW'(1);
          end
        end
      end
      v1_q <= emit;
      if (emit) begin
        c1x_q <= cx_q;
        c1y_q <= cy_q;
      end
    end
  end

  assign step_pixel = (state_q == FLUSH) ? '0 : in_pixel;
  assign tap[0]     = step_pixel;

  for (genvar j = 0; j < N_SIZE - 1; j++) begin : g_lb
    mask_line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (COLORS + 1)
    ) u_lb (
      .clk   (clk),
      .reset (reset),
      .step  (step),
      .din   (tap[j]),
      .dout  (tap[j+1])
    );
  end

  // Window shift: row j holds pixels j lines older, column i holds pixels i steps older.
  always_ff @(posedge clk) begin
    if (step) begin
      for (int j = 0; j < N_SIZE; j++) begin
        win[j][0] <= tap[j];
        for (int i = 1; i < N_SIZE; i++) begin
          win[j][i] <= win[j][i-1];
        end
      end
    end
  end

  // Per-colour count of in-frame valid cells; out-of-frame cells hide stale buffer data.
  always_comb begin : p_count
    int     row;
    int     col;
    logic   in_frame;
    row      = 0;
    col      = 0;
    in_frame = 1'b0;
    for (int c = 0; c < COLORS; c++) begin
      cnt[c] = '0;
    end
    for (int j = 0; j < N_SIZE; j++) begin
      for (int i = 0; i < N_SIZE; i++) begin
        row      = int'(c1y_q) + R - j;
        col      = int'(c1x_q) + R - i;
        in_frame = (row >= 0) && (row < IMG_H) && (col >= 0) && (col < IMG_W);
        for (int c = 0; c < COLORS; c++) begin
          if (in_frame && win[j][i][COLORS] && win[j][i][c]) begin
            cnt[c] = cnt[c] + CW'(1);
          end
        end
      end
    end
  end

  // Keep a colour bit only on a valid centre with enough same-colour support.
  always_comb begin
    centre         = win[R][R];
    result         = '0;
    result[COLORS] = centre[COLORS];
    for (int c = 0; c < COLORS; c++) begin
      result[c] = centre[c] & centre[COLORS] & (cnt[c] >= TH_C);
    end
  end

  // Output register; an aborting frame start kills the result still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_pixel <= '0;
    end else if (abort) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      out_valid <= v1_q;
      out_sof   <= v1_q && (c1x_q == '0) && (c1y_q == '0);
      if (v1_q) begin
        out_pixel <= result;
      end
    end
  end

`ifdef DENOISE_STATS_EN
  localparam int SW = $clog2(IMG_W * IMG_H + 1);

  logic          removed_bit;
  logic [SW-1:0] removed_acc, removed_next;

  // Running count of pixels that lost a colour bit; restarts on the frame's first output.
  always_comb begin
    removed_bit  = |(centre[COLORS-1:0] & ~result[COLORS-1:0]);
    removed_next = (((c1x_q == '0) && (c1y_q == '0)) ? '0 : removed_acc) + SW'(removed_bit);
  end

  // Publish the frame total alongside the last output pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      removed_acc  <= '0;
      stat_removed <= '0;
      stat_valid   <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (v1_q && !abort) begin
        removed_acc <= removed_next;
        if (c1x_q == X_LAST && c1y_q == Y_LAST) begin
          stat_removed <= removed_next;
          stat_valid   <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
